// File: rtl/wide_sub_seq_pkg.sv
// Shared types and constants for the word-serial wide subtractor.
package wide_sub_seq_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Smallest width able to index n words; evaluated at elaboration only.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/wide_sub_seq_if.sv
// Request/result bundle between a requester and wide_sub_seq.
interface wide_sub_seq_if #(
  parameter int NWORDS = 4
);
  import wide_sub_seq_pkg::*;

  logic                       start;
  logic [NWORDS*WORD_W-1:0]   a;
  logic [NWORDS*WORD_W-1:0]   b;
  logic                       busy;
  logic                       done;
  logic [NWORDS*WORD_W-1:0]   r;
  logic                       n;
  logic                       z;
  logic                       c;
  logic                       v;

  modport master (output start, a, b, input busy, done, r, n, z, c, v);
  modport slave  (input start, a, b, output busy, done, r, n, z, c, v);
endinterface

// File: rtl/wide_sub_seq_sub32_bw.sv
// Combinational 32-bit subtract-with-borrow: d = x - y - bin, bout set when x < y + bin.
module sub32_bw
  import wide_sub_seq_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic              bin,
  output logic [WORD_W-1:0] d,
  output logic              bout
);
  logic [WORD_W:0] diff;

  // The extra top bit of the widened difference is the borrow-out.
  assign diff = {1'b0, x} - {1'b0, y} - {{WORD_W{1'b0}}, bin};
  assign d    = diff[WORD_W-1:0];
  assign bout = diff[WORD_W];
endmodule

// File: rtl/wide_sub_seq.sv
// Word-serial NWORDS*32-bit subtractor: one shared 32-bit borrow unit, one word per cycle.
module wide_sub_seq
  import wide_sub_seq_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic            clk,
  input  logic            rst,
  wide_sub_seq_if.slave   bus
);
  localparam int IDX_W = clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

  typedef logic [NWORDS-1:0][WORD_W-1:0] wide_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             zacc_q, zacc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  wide_t            a_q, a_d, b_q, b_d, work_q, work_d, r_q, r_d;

  logic [WORD_W-1:0] word_d;
  logic              word_bout;
  logic              word_zero;

  sub32_bw u_sub (
    .x    (a_q[idx_q]),
    .y    (b_q[idx_q]),
    .bin  (borrow_q),
    .d    (word_d),
    .bout (word_bout)
  );

  assign word_zero = (word_d == '0);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    zacc_d   = zacc_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    r_d      = r_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          idx_d    = '0;
          borrow_d = 1'b0;
          zacc_d   = 1'b1;
          a_d      = bus.a;
          b_d      = bus.b;
        end
      end
      RUN: begin
        work_d[idx_q] = word_d;
        borrow_d      = word_bout;
        zacc_d        = zacc_q & word_zero;
        idx_d         = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          state_d = DONE;
          idx_d   = '0;
          r_d     = work_d;
          n_d     = word_d[WORD_W-1];
          z_d     = zacc_q & word_zero;
          c_d     = word_bout;
          // Signed overflow: operand signs differ and the result sign follows b.
          v_d     = (a_q[NWORDS-1][WORD_W-1] & ~b_q[NWORDS-1][WORD_W-1] & ~word_d[WORD_W-1])
                  | (~a_q[NWORDS-1][WORD_W-1] & b_q[NWORDS-1][WORD_W-1] & word_d[WORD_W-1]);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      zacc_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      r_q      <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      zacc_q   <= zacc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      r_q      <= r_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
    end
  end

  // NOTE: operand and scratch registers are left unreset; they are always written before being read.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    work_q <= work_d;
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.r    = r_q;
  assign bus.n    = n_q;
  assign bus.z    = z_q;
  assign bus.c    = c_q;
  assign bus.v    = v_q;

endmodule

// File: tb/tb_wide_sub_seq.sv
// Directed-vector bench for wide_sub_seq with NWORDS=4 (128-bit operands).
module tb_wide_sub_seq;
  localparam int NW = 4;
  localparam int W  = NW * 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  wide_sub_seq_if #(.NWORDS(NW)) bus ();

  wide_sub_seq #(.NWORDS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation; lat = edges from accept to done (-1 on timeout), busy_cnt = busy cycles before done.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.busy && !bus.done) busy_cnt++;
      if (bus.done) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.n, bus.z, bus.c, bus.v} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 000000",
               {bus.busy, bus.done, bus.n, bus.z, bus.c, bus.v});
    end
    total++;
    if (bus.r !== '0) begin
      bad++;
      $display("FAIL reset_r: got %h want 0", bus.r);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    run_op(128'd5, 128'd3, lat, bc);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
    total++;
    if (bc !== 4) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
    total++;
    if (bus.r !== 128'd2) begin bad++; $display("FAIL basic_r: got %h want 2", bus.r); end
    total++;
    if ({bus.n, bus.z, bus.c, bus.v} !== 4'b0000) begin
      bad++; $display("FAIL basic_flags: got %b want 0000", {bus.n, bus.z, bus.c, bus.v});
    end
    total++;
    if (!bus.busy) begin bad++; $display("FAIL basic_busy_in_done: got 0 want 1"); end
    @(negedge clk);
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++; $display("FAIL basic_done_pulse: got busy,done=%b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [6];
    logic [W-1:0] vb [6];
    logic [W-1:0] vr [6];
    logic [3:0]   vf [6];
    int lat, bc;
    // {n,z,c,v}
    va[0] = 128'd0;                                     vb[0] = 128'd1;
    vr[0] = {W{1'b1}};                                  vf[0] = 4'b1010;
    va[1] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    vb[1] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    vr[1] = 128'd0;                                     vf[1] = 4'b0100;
    va[2] = 128'h8000_0000_0000_0000_0000_0000_0000_0000; vb[2] = 128'd1;
    vr[2] = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF; vf[2] = 4'b0001;
    va[3] = 128'h0000_0000_0000_0000_0000_0001_0000_0000; vb[3] = 128'd1;
    vr[3] = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF; vf[3] = 4'b0000;
    va[4] = 128'd1;  vb[4] = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    vr[4] = 128'h8000_0000_0000_0000_0000_0000_0000_0001; vf[4] = 4'b1011;
    va[5] = 128'h0000_0001_0000_0000_0000_0000_0000_0000; vb[5] = 128'd1;
    vr[5] = 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF; vf[5] = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      run_op(va[k], vb[k], lat, bc);
      total++;
      if (lat !== 4) begin bad++; $display("FAIL vec%0d_latency: got %0d want 4", k, lat); end
      total++;
      if (bus.r !== vr[k]) begin
        bad++; $display("FAIL vec%0d_r: got %h want %h", k, bus.r, vr[k]);
      end
      total++;
      if ({bus.n, bus.z, bus.c, bus.v} !== vf[k]) begin
        bad++; $display("FAIL vec%0d_nzcv: got %b want %b", k, {bus.n, bus.z, bus.c, bus.v}, vf[k]);
      end
    end
  endtask

  task automatic test_hold_and_inputs();
    int lat, bc;
    bit seen;
    run_op(128'd5, 128'd3, lat, bc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 128'd10;
    bus.b     = 128'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = {W{1'b1}};
    bus.b     = 128'd7;
    @(negedge clk);
    total++;
    if (bus.r !== 128'd2 || {bus.n, bus.z, bus.c, bus.v} !== 4'b0000) begin
      bad++; $display("FAIL hold_during_run: got r=%h nzcv=%b want r=2 nzcv=0000",
                      bus.r, {bus.n, bus.z, bus.c, bus.v});
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    total++;
    if (!seen || bus.r !== 128'd6) begin
      bad++; $display("FAIL input_change: got done=%0b r=%h want done=1 r=6", seen, bus.r);
    end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int dn  [$];
    logic prev_busy;
    int rbad;
    rbad = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 128'd100;
    bus.b     = 128'd1;
    prev_busy = bus.busy;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.busy && !prev_busy) acc.push_back(i);
      if (bus.done) begin
        dn.push_back(i);
        if (bus.r !== 128'd99) rbad++;
      end
      prev_busy = bus.busy;
    end
    bus.start = 1'b0;
    total++;
    if (acc.size() < 3 || dn.size() < 2) begin
      bad++; $display("FAIL b2b_count: got accepts=%0d dones=%0d want >=3 >=2", acc.size(), dn.size());
    end else begin
      total++;
      if (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6) begin
        bad++; $display("FAIL b2b_spacing: got %0d,%0d want 6,6", acc[1] - acc[0], acc[2] - acc[1]);
      end
      total++;
      if (dn[0] - acc[0] !== 4) begin
        bad++; $display("FAIL b2b_latency: got %0d want 4", dn[0] - acc[0]);
      end
    end
    total++;
    if (rbad !== 0) begin bad++; $display("FAIL b2b_result: got %0d wrong results want 0", rbad); end
    for (int i = 0; i < 10 && bus.busy; i++) @(negedge clk);
  endtask

  task automatic test_rst_midrun();
    int lat, bc, dcount;
    run_op(128'd0, 128'd1, lat, bc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 128'd5;
    bus.b     = 128'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.n, bus.z, bus.c, bus.v} !== 6'b0 || bus.r !== '0) begin
      bad++; $display("FAIL rst_midrun: got ctl=%b r=%h want 000000 r=0",
                      {bus.busy, bus.done, bus.n, bus.z, bus.c, bus.v}, bus.r);
    end
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcount++;
    end
    total++;
    if (dcount !== 0) begin bad++; $display("FAIL rst_no_done: got %0d active cycles want 0", dcount); end
  endtask

  task automatic test_rst_vs_start();
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 128'd9;
    bus.b     = 128'd1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_priority: got busy=%b want 0", bus.busy); end
    bus.start = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_hold_and_inputs();
    test_back_to_back();
    test_rst_midrun();
    test_rst_vs_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
